// File: rtl/frame_writer.sv
// Writer side of the panel frame buffer: RGB byte stream in, 64x32 pixel
// writes into the back bank, then a bank swap handshake with the driver.
module frame_writer #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 5,
  localparam int AW = COL_BITS + ROW_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [AW-1:0] wr_addr,
  output logic [23:0]   wr_data,
  output logic          wr_en_hi,
  output logic          wr_en_lo,
  output logic          selected_buffer,
  input  logic          actual_buffer,
  output logic          frame_done,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET_R = 3'd1;
  localparam logic [2:0] S_GET_G = 3'd2;
  localparam logic [2:0] S_GET_B = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_SWAP  = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  logic [2:0]          state;
  logic [2:0]          state_nx;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                back_buf;
  logic [7:0]          r_q;
  logic [7:0]          g_q;
  logic                accept;
  logic                take_sof;
  logic                last_px;
  logic                rdy_nx;

  assign accept   = in_valid & in_ready;
  assign take_sof = accept & in_sof;
  assign last_px  = (row == '1) && (col == '1);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (take_sof) state_nx = S_GET_G;
      S_GET_R: if (accept) state_nx = S_GET_G;
      S_GET_G: begin
        if (take_sof)    state_nx = S_GET_G;
        else if (accept) state_nx = S_GET_B;
      end
      S_GET_B: begin
        if (take_sof)    state_nx = S_GET_G;
        else if (accept) state_nx = S_WRITE;
      end
      S_WRITE: state_nx = last_px ? S_SWAP : S_GET_R;
      S_SWAP:  state_nx = S_WAIT;
      S_WAIT: begin
        if (actual_buffer == back_buf)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it is low out of reset
  assign rdy_nx = (state_nx == S_IDLE)  ||
                  (state_nx == S_GET_R) ||
                  (state_nx == S_GET_G) ||
                  (state_nx == S_GET_B);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      in_ready        <= 1'b0;
      row             <= '0;
      col             <= '0;
      back_buf        <= 1'b1;
      r_q             <= '0;
      g_q             <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      wr_en_hi        <= 1'b0;
      wr_en_lo        <= 1'b0;
      selected_buffer <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state      <= state_nx;
      in_ready   <= rdy_nx;
      wr_en_hi   <= 1'b0;
      wr_en_lo   <= 1'b0;
      frame_done <= 1'b0;

      if (take_sof) begin
        r_q <= in_data;
        row <= '0;
        col <= '0;
        // bank is chosen only at a fresh frame, not on resync
        if (state == S_IDLE)
          back_buf <= ~actual_buffer;
      end else if (accept) begin
        unique case (state)
          S_GET_R: r_q <= in_data;
          S_GET_G: g_q <= in_data;
          S_GET_B: begin
            wr_data  <= {in_data, g_q, r_q};
            wr_addr  <= {back_buf,
                         row[ROW_BITS-2:0],
                         col};
            wr_en_hi <= ~row[ROW_BITS-1];
            wr_en_lo <= row[ROW_BITS-1];
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) begin
        col <= col + 1'b1;
        if (col == '1)
          row <= row + 1'b1;
        if (last_px)
          frame_done <= 1'b1;
      end

      if (state == S_SWAP)
        selected_buffer <= back_buf;
    end
  end

endmodule
